// File: rtl/mtm_alu_result_deserializer.sv
// Decodes the ALU serial response line into parallel result / error reports; pulses one clock after the stop-bit sample.
// No backpressure: the serial line cannot be stalled, so each report is a single-cycle pulse with held data fields.
module mtm_alu_result_deserializer #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sin,
  output logic        res_valid,
  output logic [31:0] res_data,
  output logic [3:0]  res_flags,
  output logic        res_crc_ok,
  output logic        err_valid,
  output logic [5:0]  err_flags,
  output logic        err_parity_ok,
  output logic        frame_err,
  output logic        busy
);

  localparam int            CW   = 5;
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_SHIFT, S_CHECK} bit_state_e;

  bit_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_idx_q, bit_idx_d;
  logic [9:0]    shift_q, shift_d;
  logic [2:0]    n_q, n_d;
  logic [31:0]   acc_q, acc_d;

  logic          res_valid_q, res_valid_d;
  logic [31:0]   res_data_q, res_data_d;
  logic [3:0]    res_flags_q, res_flags_d;
  logic          res_crc_ok_q, res_crc_ok_d;
  logic          err_valid_q, err_valid_d;
  logic [5:0]    err_flags_q, err_flags_d;
  logic          err_parity_ok_q, err_parity_ok_d;
  logic          frame_err_q, frame_err_d;
  logic          busy_q, busy_d;

  // Captured packet after 10 samples: {type, payload[7:0], stop}
  logic          pkt_ctl;
  logic [7:0]    pkt_payload;
  logic          pkt_stop;

  assign pkt_ctl     = shift_q[9];
  assign pkt_payload = shift_q[8:1];
  assign pkt_stop    = shift_q[0];

  // CRC3, polynomial x^3+x+1, init 0, message MSB first
  function automatic logic [2:0] crc3(input logic [36:0] msg);
    logic [2:0] c;
    logic       fb;
    c = 3'b000;
    for (int i = 36; i >= 0; i--) begin
      fb = c[2] ^ msg[i];
      c  = {c[1], c[0] ^ fb, fb};
    end
    return c;
  endfunction

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    bit_idx_d       = bit_idx_q;
    shift_d         = shift_q;
    n_d             = n_q;
    acc_d           = acc_q;
    res_valid_d     = 1'b0;
    res_data_d      = res_data_q;
    res_flags_d     = res_flags_q;
    res_crc_ok_d    = res_crc_ok_q;
    err_valid_d     = 1'b0;
    err_flags_d     = err_flags_q;
    err_parity_ok_d = err_parity_ok_q;
    frame_err_d     = 1'b0;
    busy_d          = busy_q;

    case (state_q)
      S_IDLE, S_CHECK: begin
        if (state_q == S_CHECK) begin
          state_d = S_IDLE;
          if (!pkt_stop) begin
            frame_err_d = 1'b1;
            n_d         = 3'd0;
            busy_d      = 1'b0;
          end else if (!pkt_ctl) begin
            if (n_q == 3'd4) begin
              frame_err_d = 1'b1;
              n_d         = 3'd0;
              busy_d      = 1'b0;
            end else begin
              acc_d = {acc_q[23:0], pkt_payload};
              n_d   = n_q + 3'd1;
            end
          end else if (n_q == 3'd0 && pkt_payload[7]) begin
            err_valid_d     = 1'b1;
            err_flags_d     = pkt_payload[6:1];
            err_parity_ok_d = ~(^pkt_payload);
            busy_d          = 1'b0;
          end else if (n_q == 3'd4 && !pkt_payload[7]) begin
            res_valid_d  = 1'b1;
            res_data_d   = acc_q;
            res_flags_d  = pkt_payload[6:3];
            res_crc_ok_d = (pkt_payload[2:0] == crc3({acc_q, 1'b0, pkt_payload[6:3]}));
            n_d          = 3'd0;
            busy_d       = 1'b0;
          end else begin
            frame_err_d = 1'b1;
            n_d         = 3'd0;
            busy_d      = 1'b0;
          end
        end
        // Start detection also runs during CHECK so slow-sampling configs keep up with zero-gap packets
        if (!sin) begin
          bit_idx_d = 4'd0;
          if (HALF == '0) begin
            state_d = S_SHIFT;
            cnt_d   = '0;
            busy_d  = 1'b1;
          end else begin
            state_d = S_START;
            cnt_d   = ONE;
          end
        end
      end

      S_START: begin
        if (cnt_q == HALF) begin
          cnt_d = '0;
          if (!sin) begin
            state_d = S_SHIFT;
            busy_d  = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end

      S_SHIFT: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          shift_d = {shift_q[8:0], sin};
          if (bit_idx_q == 4'd9) begin
            state_d = S_CHECK;
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      bit_idx_q       <= '0;
      shift_q         <= '0;
      n_q             <= '0;
      acc_q           <= '0;
      res_valid_q     <= 1'b0;
      res_data_q      <= '0;
      res_flags_q     <= '0;
      res_crc_ok_q    <= 1'b0;
      err_valid_q     <= 1'b0;
      err_flags_q     <= '0;
      err_parity_ok_q <= 1'b0;
      frame_err_q     <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      bit_idx_q       <= bit_idx_d;
      shift_q         <= shift_d;
      n_q             <= n_d;
      acc_q           <= acc_d;
      res_valid_q     <= res_valid_d;
      res_data_q      <= res_data_d;
      res_flags_q     <= res_flags_d;
      res_crc_ok_q    <= res_crc_ok_d;
      err_valid_q     <= err_valid_d;
      err_flags_q     <= err_flags_d;
      err_parity_ok_q <= err_parity_ok_d;
      frame_err_q     <= frame_err_d;
      busy_q          <= busy_d;
    end
  end

  assign res_valid     = res_valid_q;
  assign res_data      = res_data_q;
  assign res_flags     = res_flags_q;
  assign res_crc_ok    = res_crc_ok_q;
  assign err_valid     = err_valid_q;
  assign err_flags     = err_flags_q;
  assign err_parity_ok = err_parity_ok_q;
  assign frame_err     = frame_err_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_mtm_alu_result_deserializer.sv
// Scoreboard bench: two decoders (1 and 4 clocks per bit) fed directed packet streams with hand-computed results.
module tb_mtm_alu_result_deserializer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sin_a = 1'b1;
  logic sin_b = 1'b1;

  always #5 clk = ~clk;

  logic        res_valid_a, res_crc_ok_a, err_valid_a, err_parity_ok_a, frame_err_a, busy_a;
  logic [31:0] res_data_a;
  logic [3:0]  res_flags_a;
  logic [5:0]  err_flags_a;
  logic        res_valid_b, res_crc_ok_b, err_valid_b, err_parity_ok_b, frame_err_b, busy_b;
  logic [31:0] res_data_b;
  logic [3:0]  res_flags_b;
  logic [5:0]  err_flags_b;

  mtm_alu_result_deserializer #(.CLKS_PER_BIT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .sin(sin_a),
    .res_valid(res_valid_a), .res_data(res_data_a), .res_flags(res_flags_a), .res_crc_ok(res_crc_ok_a),
    .err_valid(err_valid_a), .err_flags(err_flags_a), .err_parity_ok(err_parity_ok_a),
    .frame_err(frame_err_a), .busy(busy_a)
  );

  mtm_alu_result_deserializer #(.CLKS_PER_BIT(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .sin(sin_b),
    .res_valid(res_valid_b), .res_data(res_data_b), .res_flags(res_flags_b), .res_crc_ok(res_crc_ok_b),
    .err_valid(err_valid_b), .err_flags(err_flags_b), .err_parity_ok(err_parity_ok_b),
    .frame_err(frame_err_b), .busy(busy_b)
  );

  logic [47:0] outs_a, outs_b;
  assign outs_a = {res_valid_a, res_data_a, res_flags_a, res_crc_ok_a, err_valid_a, err_flags_a,
                   err_parity_ok_a, frame_err_a, busy_a};
  assign outs_b = {res_valid_b, res_data_b, res_flags_b, res_crc_ok_b, err_valid_b, err_flags_b,
                   err_parity_ok_b, frame_err_b, busy_b};

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] data;
    logic [3:0]  flags;
    logic        crc_ok;
    logic [5:0]  eflags;
    logic        par_ok;
  } ev_t;

  localparam logic [1:0] K_RES = 2'd1;
  localparam logic [1:0] K_ERR = 2'd2;
  localparam logic [1:0] K_FE  = 2'd3;

  ev_t exp_a[$];
  ev_t exp_b[$];
  int  checks = 0;
  int  errors = 0;
  logic [31:0] prev_data_a = '0;
  logic [31:0] prev_data_b = '0;

  function automatic ev_t ex_res(input logic [31:0] d, input logic [3:0] f, input logic c);
    ev_t e;
    e = '0; e.kind = K_RES; e.data = d; e.flags = f; e.crc_ok = c;
    return e;
  endfunction

  function automatic ev_t ex_err(input logic [5:0] ef, input logic p);
    ev_t e;
    e = '0; e.kind = K_ERR; e.eflags = ef; e.par_ok = p;
    return e;
  endfunction

  function automatic ev_t ex_fe();
    ev_t e;
    e = '0; e.kind = K_FE;
    return e;
  endfunction

  // kind stays 0 when more than one pulse is active at once
  function automatic ev_t obs(input logic rv, input logic evl, input logic fe, input logic [31:0] d,
                              input logic [3:0] f, input logic c, input logic [5:0] ef, input logic p);
    ev_t e;
    e = '0;
    if (rv && !evl && !fe) begin
      e.kind = K_RES; e.data = d; e.flags = f; e.crc_ok = c;
    end else if (evl && !rv && !fe) begin
      e.kind = K_ERR; e.eflags = ef; e.par_ok = p;
    end else if (fe && !rv && !evl) begin
      e.kind = K_FE;
    end
    return e;
  endfunction

  task automatic cmp_ev(input string who, input ev_t got, input ev_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got kind=%0d data=%h flags=%h crc_ok=%b eflags=%b par_ok=%b, expected kind=%0d data=%h flags=%h crc_ok=%b eflags=%b par_ok=%b",
               who, got.kind, got.data, got.flags, got.crc_ok, got.eflags, got.par_ok,
               exp.kind, exp.data, exp.flags, exp.crc_ok, exp.eflags, exp.par_ok);
    end
  endtask

  task automatic chk(input string name, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin : mon_a
    ev_t got;
    if (rst_n && (res_valid_a || err_valid_a || frame_err_a)) begin
      got = obs(res_valid_a, err_valid_a, frame_err_a, res_data_a, res_flags_a, res_crc_ok_a,
                err_flags_a, err_parity_ok_a);
      if (exp_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut_a unexpected event: got kind=%0d, expected none", got.kind);
      end else begin
        cmp_ev("dut_a event", got, exp_a.pop_front());
      end
    end
    if (rst_n && res_data_a !== prev_data_a) begin
      checks++;
      if (!res_valid_a) begin
        errors++;
        $display("FAIL dut_a res_data hold: changed to %h without res_valid, required held %h", res_data_a, prev_data_a);
      end
    end
    prev_data_a = res_data_a;
  end

  always @(negedge clk) begin : mon_b
    ev_t got;
    if (rst_n && (res_valid_b || err_valid_b || frame_err_b)) begin
      got = obs(res_valid_b, err_valid_b, frame_err_b, res_data_b, res_flags_b, res_crc_ok_b,
                err_flags_b, err_parity_ok_b);
      if (exp_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut_b unexpected event: got kind=%0d, expected none", got.kind);
      end else begin
        cmp_ev("dut_b event", got, exp_b.pop_front());
      end
    end
    if (rst_n && res_data_b !== prev_data_b) begin
      checks++;
      if (!res_valid_b) begin
        errors++;
        $display("FAIL dut_b res_data hold: changed to %h without res_valid, required held %h", res_data_b, prev_data_b);
      end
    end
    prev_data_b = res_data_b;
  end

  task automatic push(input int which, input ev_t e);
    if (which == 0) exp_a.push_back(e);
    else            exp_b.push_back(e);
  endtask

  // Called on a negedge; each bit is held for CLKS_PER_BIT cycles of the chosen DUT
  task automatic send_pkt(input int which, input logic typ, input logic [7:0] p, input logic stop, input int gap);
    logic [10:0] bits;
    int          cpb;
    bits = {1'b0, typ, p, stop};
    cpb  = (which == 0) ? 1 : 4;
    for (int i = 10; i >= 0; i--) begin
      if (which == 0) sin_a = bits[i];
      else            sin_b = bits[i];
      repeat (cpb) @(negedge clk);
    end
    if (which == 0) sin_a = 1'b1;
    else            sin_b = 1'b1;
    repeat (gap * cpb) @(negedge clk);
  endtask

  task automatic send_resp(input int which, input logic [31:0] word, input logic [7:0] ctl, input int gap, input ev_t e);
    push(which, e);
    for (int i = 3; i >= 0; i--) send_pkt(which, 1'b0, word[8*i +: 8], 1'b1, gap);
    send_pkt(which, 1'b1, ctl, 1'b1, gap);
  endtask

  task automatic drain(input int which);
    for (int i = 0; i < 400; i++) begin
      if ((which == 0 ? exp_a.size() : exp_b.size()) == 0) break;
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    checks++;
    if ((which == 0 ? exp_a.size() : exp_b.size()) != 0) begin
      errors++;
      $display("FAIL drain dut%0d: %0d expected events never seen, required 0",
               which, (which == 0 ? exp_a.size() : exp_b.size()));
    end
  endtask

  task automatic run_vectors(input int which, input int gap);
    send_resp(which, 32'h00000000, 8'h00, gap, ex_res(32'h00000000, 4'h0, 1'b1));
    send_resp(which, 32'h00000000, 8'h01, gap, ex_res(32'h00000000, 4'h0, 1'b0));
    send_resp(which, 32'h12345678, 8'h06, gap, ex_res(32'h12345678, 4'h0, 1'b1));
    send_resp(which, 32'h00000000, 8'h53, gap, ex_res(32'h00000000, 4'hA, 1'b1));
    push(which, ex_err(6'b100100, 1'b1)); send_pkt(which, 1'b1, 8'hC9, 1'b1, gap);
    push(which, ex_err(6'b100100, 1'b0)); send_pkt(which, 1'b1, 8'hC8, 1'b1, gap);
    // bad stop bit on the 2nd data packet, then a clean response
    push(which, ex_fe());
    send_pkt(which, 1'b0, 8'h11, 1'b1, gap);
    send_pkt(which, 1'b0, 8'h22, 1'b0, gap);
    send_resp(which, 32'hFFFFFFFF, 8'h03, gap, ex_res(32'hFFFFFFFF, 4'h0, 1'b1));
    // ctl after two data packets
    push(which, ex_fe());
    send_pkt(which, 1'b0, 8'h01, 1'b1, gap);
    send_pkt(which, 1'b0, 8'h02, 1'b1, gap);
    send_pkt(which, 1'b1, 8'h00, 1'b1, gap);
    // result-type ctl with no data
    push(which, ex_fe()); send_pkt(which, 1'b1, 8'h00, 1'b1, gap);
    // error-type ctl after four data packets
    send_resp(which, 32'hFFFFFFFF, 8'h80, gap, ex_fe());
    // fifth data packet
    push(which, ex_fe());
    for (int i = 0; i < 5; i++) send_pkt(which, 1'b0, 8'h00, 1'b1, gap);
    send_resp(which, 32'h00000000, 8'h00, gap, ex_res(32'h00000000, 4'h0, 1'b1));
    drain(which);
  endtask

  initial begin : watchdog
    #500000;
    errors++;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : main
    logic bad_a, bad_b;
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    chk("reset outputs dut_a", outs_a, 48'h0);
    chk("reset outputs dut_b", outs_b, 48'h0);
    rst_n = 1'b1;

    bad_a = 1'b0; bad_b = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (outs_a !== 48'h0) bad_a = 1'b1;
      if (outs_b !== 48'h0) bad_b = 1'b1;
    end
    chk("idle outputs dut_a", {47'h0, bad_a}, 48'h0);
    chk("idle outputs dut_b", {47'h0, bad_b}, 48'h0);

    run_vectors(0, 1);
    run_vectors(1, 0);

    // busy spans the gap between data packets of one response
    push(0, ex_res(32'h12345678, 4'h0, 1'b1));
    send_pkt(0, 1'b0, 8'h12, 1'b1, 1);
    send_pkt(0, 1'b0, 8'h34, 1'b1, 1);
    chk("busy between data packets", {47'h0, busy_a}, 48'h1);
    send_pkt(0, 1'b0, 8'h56, 1'b1, 1);
    send_pkt(0, 1'b0, 8'h78, 1'b1, 1);
    send_pkt(0, 1'b1, 8'h06, 1'b1, 1);
    drain(0);
    chk("busy after response", {47'h0, busy_a}, 48'h0);
    chk("res_data held", {16'h0, res_data_a}, {16'h0, 32'h12345678});

    // reset in the middle of a packet
    sin_a = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy mid packet", {47'h0, busy_a}, 48'h1);
    rst_n = 1'b0;
    #1;
    chk("async reset outputs dut_a", outs_a, 48'h0);
    @(negedge clk);
    sin_a = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    send_resp(0, 32'hFFFFFFFF, 8'h03, 1, ex_res(32'hFFFFFFFF, 4'h0, 1'b1));
    drain(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mtm_alu_result_deserializer.md
Name: mtm_alu_result_deserializer

Overview:
- Downstream consumer of the ALU serial output line `sout`.
- Samples the serial stream, reassembles 11-bit packets and groups them into complete ALU responses.
- Presents each response as a parallel result (data, flags, CRC check) or as an error report (error flags, parity check).
- Used by the bench monitor/scoreboard and by any parallel-bus wrapper around the ALU.

Parameters:
- CLKS_PER_BIT, 1, clocks per serial bit. Legal range 1..16. Bit is sampled at count CLKS_PER_BIT/2 (integer division) after the bit edge.

Ports:
- clk  input  1  posedge clock
- rst_n  input  1  asynchronous active-low reset
- sin  input  1  serial line from ALU `sout`; idle high
- res_valid  output  1  one-cycle pulse: normal response complete
- res_data  output  32  result C; MSB byte received first
- res_flags  output  4  {carry, overflow, zero, negative} from the control packet
- res_crc_ok  output  1  received CRC3 matches computed CRC3
- err_valid  output  1  one-cycle pulse: error response complete
- err_flags  output  6  error flags from the error packet
- err_parity_ok  output  1  error-packet parity correct
- frame_err  output  1  one-cycle pulse: bad stop bit or illegal packet sequence
- busy  output  1  high from start-bit detect until the response completes or is aborted

Behaviour:
- Reset value of every output is 0. Reset is async assert and sync-safe deassert; it may arrive mid-packet, and the partial response is discarded.
- Packet format, MSB first: start(0), type(0=data, 1=ctl), payload[7:0], stop(1). Total 11 bits.
- Bit FSM states:
  - IDLE: a low `sin` at the sample point means start.
  - SHIFT: capture 10 bits, one per CLKS_PER_BIT clocks.
  - CHECK: one cycle to evaluate the packet, then back to IDLE.
  - A start glitch (sin high again at the mid-sample) returns to IDLE with no error.
- Response FSM, driven by data-packet count n:
  - n=0, ctl with payload[7]=1: error response. err_flags=payload[6:1]. err_parity_ok = XOR of payload[7:0] == 0 (even parity).
  - n=0..3, data packet: shift payload into res_data from the LSB side; n++.
  - n=4, ctl with payload[7]=0: normal response. res_flags=payload[6:3]. res_crc_ok = (payload[2:0] == CRC3).
  - CRC3 definition: computed over the 37-bit vector {C[31:0], 1'b0, flags[3:0]}, MSB first, polynomial x^3+x+1, initial value 0.
- Illegal sequences:
  - ctl packet with n=1..3
  - data packet with n=4
  - ctl with payload[7]=0 at n=0
  - ctl with payload[7]=1 at n=4
- On any illegal sequence, or a stop bit of 0: pulse frame_err, clear n, and suppress res_valid/err_valid for that response.
- Latency: res_valid, err_valid and frame_err pulse in the clock after the stop-bit sample.
- res_data, res_flags, res_crc_ok, err_flags and err_parity_ok are updated in the same cycle as their valid pulse and held until the next valid pulse. res_data must not be visible partially updated.
- A new start bit is accepted in the first cycle after CHECK, so back-to-back packets with zero idle bits are legal.
- busy:
  - rises on start detect of the first packet of a response;
  - falls together with the valid or frame_err pulse;
  - stays high between the data packets of one response.

Test Plan:
- Reset then idle: sin=1 held for 100 cycles -> all outputs stay 0.
- Four data packets 0x00, then ctl 0x00 -> res_valid pulse once, res_data=0x00000000, res_flags=0, res_crc_ok=1.
- Same stimulus with ctl 0x01 -> res_valid=1, res_crc_ok=0. Data packets 0x12,0x34,0x56,0x78 -> res_data=0x12345678.
- Single ctl packet 0xC9 -> err_valid pulse, err_flags=6'b100100, err_parity_ok=1. Ctl 0xC8 -> err_parity_ok=0.
- Stop bit 0 on the 2nd data packet -> frame_err pulse, no res_valid. The next well-formed 5-packet response decodes correctly.
- Two data packets then a ctl -> frame_err. rst_n asserted mid-SHIFT -> outputs 0 immediately. CLKS_PER_BIT=4, back-to-back packets -> same results as CLKS_PER_BIT=1.
